// File: rtl/down_counter_timer_pkg.sv
// rtl/down_counter_timer_pkg.sv - shared state encodings and mode constants for the down-counter/timer
package down_counter_timer_pkg;

    // IDLE: never loaded or loaded with zero; RUN: counting; DONE: one-shot expired
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/down_counter_timer_dec_borrow_chain.sv
// rtl/down_counter_timer_dec_borrow_chain.sv - gate-primitive ripple-borrow decrementer with count==1 detect
//
// Ports:
//   count   in   WIDTH  value to decrement
//   dec     out  WIDTH  count-1 (modulo 2^WIDTH)
//   is_one  out  1      high when count==1
module dec_borrow_chain #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] dec,
    output logic             is_one
);

    logic [WIDTH-1:0] ncount;
    logic [WIDTH-1:0] borrow;
    logic [WIDTH-1:0] hi_zero;

    // The decrement always borrows into bit 0.
    assign borrow[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            not u_inv (ncount[i], count[i]);
            xor u_diff (dec[i], count[i], borrow[i]);
            if (i > 0) begin : g_borrow
                // Borrow ripples upward through every zero bit below.
                and u_brw (borrow[i], borrow[i-1], ncount[i-1]);
            end
        end

        // hi_zero[k] is high when bits 1..k are all zero; bit 0 slot is unused.
        assign hi_zero[0] = 1'b1;
        for (i = 1; i < WIDTH; i++) begin : g_zero
            if (i == 1) begin : g_first
                and u_z (hi_zero[i], hi_zero[0], ncount[1]);
            end else begin : g_next
                and u_z (hi_zero[i], hi_zero[i-1], ncount[i]);
            end
        end
    endgenerate

    and u_one (is_one, count[0], hi_zero[WIDTH-1]);

endmodule

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable down-counter/timer with one-shot and periodic modes
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous reset, active-high
//   en        in   1      count enable, one decrement per enabled cycle
//   load      in   1      load strobe, captures load_val and mode
//   load_val  in   WIDTH  start/reload value
//   mode      in   1      0 = one-shot, 1 = periodic; sampled only on load
//   count     out  WIDTH  current count
//   tc        out  1      one-cycle terminal-count pulse
//   busy      out  1      high while counting
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             tc_q, tc_d;
    logic             busy_q;

    logic [WIDTH-1:0] dec;
    logic             is_one;

    dec_borrow_chain #(.WIDTH(WIDTH)) u_dec (
        .count  (count_q),
        .dec    (dec),
        .is_one (is_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= MODE_ONESHOT;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tc_q     <= tc_d;
            // busy tracks the next state so it falls together with the one-shot tc.
            busy_q   <= (state_d == ST_RUN);
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;

        if (load) begin
            // load wins over en: no decrement in the load cycle
            count_d  = load_val;
            reload_d = load_val;
            mode_d   = mode;
            state_d  = (load_val != '0) ? ST_RUN : ST_IDLE;
        end else if (state_q == ST_RUN && en) begin
            if (is_one) begin
                tc_d = 1'b1;
                if (mode_q == MODE_PERIODIC) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = ST_DONE;
                end
            end else begin
                count_d = dec;
            end
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// tb/tb_down_counter_timer.sv - directed self-checking bench for down_counter_timer
module tb_down_counter_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       mode = 1'b0;
    logic [3:0] count;
    logic       tc;
    logic       busy;

    logic       en2 = 1'b0;
    logic       load2 = 1'b0;
    logic [1:0] load_val2 = 2'd0;
    logic       mode2 = 1'b0;
    logic [1:0] count2;
    logic       tc2;
    logic       busy2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    down_counter_timer #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .count    (count),
        .tc       (tc),
        .busy     (busy)
    );

    down_counter_timer #(.WIDTH(2)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .en       (en2),
        .load     (load2),
        .load_val (load_val2),
        .mode     (mode2),
        .count    (count2),
        .tc       (tc2),
        .busy     (busy2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [3:0] c, input logic t, input logic b);
        chk({tag, ".count"}, {28'd0, count}, {28'd0, c});
        chk({tag, ".tc"}, {31'd0, tc}, {31'd0, t});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    endtask

    task automatic chk2(input string tag, input logic [1:0] c, input logic t, input logic b);
        chk({tag, ".count"}, {30'd0, count2}, {30'd0, c});
        chk({tag, ".tc"}, {31'd0, tc2}, {31'd0, t});
        chk({tag, ".busy"}, {31'd0, busy2}, {31'd0, b});
    endtask

    initial begin
        logic [6:0] en_pat;
        logic [3:0] exp_cnt [7];

        // Reset
        rst = 1'b1;
        step();
        chk3("reset", 4'd0, 1'b0, 1'b0);
        chk2("reset_w2", 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // One-shot load 3 with en held
        load = 1'b1; load_val = 4'd3; mode = 1'b0; en = 1'b1;
        step(); chk3("os_load", 4'd3, 1'b0, 1'b1);
        load = 1'b0;
        step(); chk3("os_2", 4'd2, 1'b0, 1'b1);
        step(); chk3("os_1", 4'd1, 1'b0, 1'b1);
        step(); chk3("os_0", 4'd0, 1'b1, 1'b0);
        step(); chk3("os_done", 4'd0, 1'b0, 1'b0);
        step(); chk3("os_done2", 4'd0, 1'b0, 1'b0);

        // Periodic load 3
        load = 1'b1; load_val = 4'd3; mode = 1'b1;
        step(); chk3("per_load", 4'd3, 1'b0, 1'b1);
        load = 1'b0;
        step(); chk3("per_2", 4'd2, 1'b0, 1'b1);
        step(); chk3("per_1", 4'd1, 1'b0, 1'b1);
        step(); chk3("per_wrap", 4'd3, 1'b1, 1'b1);
        step(); chk3("per_2b", 4'd2, 1'b0, 1'b1);
        step(); chk3("per_1b", 4'd1, 1'b0, 1'b1);
        step(); chk3("per_wrap2", 4'd3, 1'b1, 1'b1);

        // One-shot load 5 with gapped enable
        load = 1'b1; load_val = 4'd5; mode = 1'b0; en = 1'b0;
        step(); chk3("gap_load", 4'd5, 1'b0, 1'b1);
        load = 1'b0;
        en_pat = 7'b1111001;
        exp_cnt[0] = 4'd4; exp_cnt[1] = 4'd4; exp_cnt[2] = 4'd4; exp_cnt[3] = 4'd3;
        exp_cnt[4] = 4'd2; exp_cnt[5] = 4'd1; exp_cnt[6] = 4'd0;
        for (int i = 0; i < 7; i++) begin
            en = en_pat[i];
            step();
            chk3($sformatf("gap_%0d", i), exp_cnt[i], (i == 6), (i != 6));
        end

        // Load with concurrent enable while running
        load = 1'b1; load_val = 4'd7; mode = 1'b0; en = 1'b1;
        step(); chk3("ld_en_7", 4'd7, 1'b0, 1'b1);
        load = 1'b0;
        step(); step();
        chk3("ld_en_5", 4'd5, 1'b0, 1'b1);
        load = 1'b1; load_val = 4'd9;
        step(); chk3("ld_en_9", 4'd9, 1'b0, 1'b1);
        load = 1'b0;
        step(); chk3("ld_en_8", 4'd8, 1'b0, 1'b1);

        // Load zero goes idle, en has no effect
        load = 1'b1; load_val = 4'd0; mode = 1'b1;
        step(); chk3("zero_load", 4'd0, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); chk3($sformatf("zero_en_%0d", i), 4'd0, 1'b0, 1'b0);
        end

        // Reset mid-run in periodic mode
        load = 1'b1; load_val = 4'd4; mode = 1'b1; en = 1'b1;
        step(); load = 1'b0;
        step(); step();
        chk3("rst_pre", 4'd2, 1'b0, 1'b1);
        rst = 1'b1;
        step(); chk3("rst_mid", 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk3($sformatf("rst_after_%0d", i), 4'd0, 1'b0, 1'b0);
        end

        // Full-range load value
        load = 1'b1; load_val = 4'd15; mode = 1'b0;
        step(); chk3("full_load", 4'd15, 1'b0, 1'b1);
        load = 1'b0;
        step(); chk3("full_14", 4'd14, 1'b0, 1'b1);
        en = 1'b0;
        step(); chk3("full_hold", 4'd14, 1'b0, 1'b1);

        // WIDTH=2, load 3 one-shot then periodic
        load2 = 1'b1; load_val2 = 2'd3; mode2 = 1'b0; en2 = 1'b1;
        step(); chk2("w2_os_3", 2'd3, 1'b0, 1'b1);
        load2 = 1'b0;
        step(); chk2("w2_os_2", 2'd2, 1'b0, 1'b1);
        step(); chk2("w2_os_1", 2'd1, 1'b0, 1'b1);
        step(); chk2("w2_os_0", 2'd0, 1'b1, 1'b0);
        step(); chk2("w2_os_done", 2'd0, 1'b0, 1'b0);
        load2 = 1'b1; mode2 = 1'b1;
        step(); chk2("w2_per_3", 2'd3, 1'b0, 1'b1);
        load2 = 1'b0;
        step(); chk2("w2_per_2", 2'd2, 1'b0, 1'b1);
        step(); chk2("w2_per_1", 2'd1, 1'b0, 1'b1);
        step(); chk2("w2_per_wrap", 2'd3, 1'b1, 1'b1);
        step(); chk2("w2_per_2b", 2'd2, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
